// File: rtl/mac_seq.sv
// mac_seq: sequencer for a half-precision dot product.
//
// It accepts a command carrying a length and then pulls that many A/B operand
// pairs from two streams. Each pair goes to an external MAC datapath, with
// mac_a_tlast marking the final pair. The sequencer then waits for the MAC
// to return its accumulated result, flagged by mac_r_tlast, and holds that
// result on the res_* handshake until it is accepted.
//
// Ports
//   aclk, aresetn               clock; asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_len command handshake; length is in element pairs
//   a_t*, b_t*                  operand streams (IEEE half). A pair moves only
//                               when both streams are valid in the same cycle.
//   mac_a_tdata/mac_b_tdata     registered operands to the MAC. The value is
//                               0x0000 in any cycle without a transfer.
//   mac_a_tlast                 registered, marks the last pair
//   mac_r_tdata/mac_r_tlast     MAC result and its end marker (DRAIN only)
//   res_tvalid/res_ready/res_tdata  dot-product result handshake
//   busy                        state is not IDLE
//   err                         watchdog fired (only with MAC_SEQ_TIMEOUT_EN)
//
// Build option
//   MAC_SEQ_TIMEOUT_EN  adds a DRAIN watchdog and the err port. If TIMEOUT
//                       DRAIN cycles pass without mac_r_tlast, the block
//                       returns qNaN (0x7E00) and sets err. Without this
//                       option, DRAIN waits indefinitely.
module mac_seq #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             a_tvalid,
    output logic             a_tready,
    input  logic [15:0]      a_tdata,
    input  logic             b_tvalid,
    output logic             b_tready,
    input  logic [15:0]      b_tdata,
    output logic [15:0]      mac_a_tdata,
    output logic [15:0]      mac_b_tdata,
    output logic             mac_a_tlast,
    input  logic [15:0]      mac_r_tdata,
    input  logic             mac_r_tlast,
    output logic             res_tvalid,
    input  logic             res_ready,
    output logic [15:0]      res_tdata,
    output logic             busy
`ifdef MAC_SEQ_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    if (LEN_W < 1 || TIMEOUT < 1) begin : g_param_chk
        $error("mac_seq: LEN_W and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             xfer;

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] drain_cnt;
`endif

    // Both readies follow the joint valid. Because of this, a pair is only
    // consumed when A and B transfer together.
    assign xfer     = (state == STREAM) && a_tvalid && b_tvalid;
    assign a_tready = xfer;
    assign b_tready = xfer;
    assign busy     = (state != IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            remaining   <= '0;
            cmd_ready   <= 1'b0;
            res_tvalid  <= 1'b0;
            res_tdata   <= 16'h0000;
            mac_a_tdata <= 16'h0000;
            mac_b_tdata <= 16'h0000;
            mac_a_tlast <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            err         <= 1'b0;
            drain_cnt   <= '0;
`endif
        end else begin
            // Idle cycles feed +0 * +0 so the MAC accumulator is unchanged.
            mac_a_tdata <= 16'h0000;
            mac_b_tdata <= 16'h0000;
            mac_a_tlast <= 1'b0;

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            // Empty dot product: answer +0 without touching the MAC.
                            res_tdata  <= 16'h0000;
                            res_tvalid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end

                STREAM: begin
                    if (xfer) begin
                        mac_a_tdata <= a_tdata;
                        mac_b_tdata <= b_tdata;
                        mac_a_tlast <= (remaining == LEN_W'(1));
                        if (remaining != '0)
                            remaining <= remaining - LEN_W'(1);
                        if (remaining <= LEN_W'(1)) begin
                            state <= DRAIN;
`ifdef MAC_SEQ_TIMEOUT_EN
                            drain_cnt <= '0;
`endif
                        end
                    end
                end

                DRAIN: begin
                    if (mac_r_tlast) begin
                        res_tdata  <= mac_r_tdata;
                        res_tvalid <= 1'b1;
                        state      <= DONE;
                    end
`ifdef MAC_SEQ_TIMEOUT_EN
                    else if (drain_cnt == CNT_LAST) begin
                        res_tdata  <= 16'h7E00;
                        res_tvalid <= 1'b1;
                        err        <= 1'b1;
                        state      <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
`endif
                end

                DONE: begin
                    // res_tdata is left alone here so it stays stable until accepted.
                    if (res_ready) begin
                        res_tvalid <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= IDLE;
`ifdef MAC_SEQ_TIMEOUT_EN
                        err        <= 1'b0;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the vector-length field.
REQ-002 SHALL have parameter TIMEOUT, default 64, max DRAIN cycles awaiting mac_r_tlast.
REQ-003 aclk  in  1  single clock; all logic on posedge aclk.
REQ-004 aresetn  in  1  reset; asynchronous, active-low.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-006 cmd_len  in  LEN_W  number of element pairs in the dot product.
REQ-007 a_tvalid / a_tready / a_tdata  in / out / in  1 / 1 / 16  operand A stream, IEEE half.
REQ-008 b_tvalid / b_tready / b_tdata  in / out / in  1 / 1 / 16  operand B stream, IEEE half.
REQ-009 mac_a_tdata / mac_b_tdata / mac_a_tlast  out  16 / 16 / 1  drive the mac datapath, registered.
REQ-010 mac_r_tdata / mac_r_tlast  in  16 / 1  mac accumulator result and end marker.
REQ-011 res_tvalid / res_ready / res_tdata  out / in / out  1 / 1 / 16  dot-product result handshake.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-014 IDLE: cmd_ready=1; on cmd_valid, latch cmd_len into remaining counter; len>0 -> STREAM, len=0 -> DONE with res_tdata=0x0000 next cycle.
REQ-015 STREAM: a_tready=b_tready=a_tvalid&b_tvalid; a pair transfers only when both valid, same cycle on both streams.
REQ-016 On transfer: next cycle mac_a_tdata<=a_tdata, mac_b_tdata<=b_tdata, remaining decrements; mac_a_tlast=1 only for the pair with remaining==1.
REQ-017 Every cycle without a transfer (any state): mac_a_tdata=mac_b_tdata=0x0000, mac_a_tlast=0 (+0 product keeps accumulation unchanged).
REQ-018 Last pair transferred -> DRAIN next cycle; a_tready/b_tready=0 outside STREAM.
REQ-019 DRAIN: on mac_r_tlast=1 capture mac_r_tdata into res_tdata, res_tvalid=1, -> DONE.
REQ-020 mac_r_tlast outside DRAIN SHALL be ignored.
REQ-021 DONE: res_tvalid=1, res_tdata stable until res_ready=1; then -> IDLE same edge; cmd_ready=0 in DONE (no overlap of commands).
REQ-022 Remaining counter LEN_W bits, no wrap: never decrements below 0.
REQ-023 No arithmetic on operand data; values pass through unmodified.

Reset
REQ-024 aresetn=0 SHALL asynchronously force IDLE, counters 0, cmd_ready=0 while asserted, res_tvalid=0, res_tdata=0x0000, mac_* outputs 0, busy=0, err=0.
REQ-025 Reset mid-STREAM/DRAIN SHALL abandon the command with no result; first cycle after release cmd_ready=1.

Configuration
REQ-026 Macro MAC_SEQ_TIMEOUT_EN SHALL compile in a DRAIN watchdog and output port err (1 bit).
REQ-027 With it: DRAIN cycle counter; if TIMEOUT cycles elapse without mac_r_tlast, -> DONE with res_tdata=0x7E00 (qNaN), err=1 held until result accepted.
REQ-028 Without it: no err port, no counter; DRAIN waits indefinitely.

Verification
REQ-029 cmd_len=3, A={0x3C00,0x4000,0x4200}, B={0x3C00,0x3C00,0x3C00} all valid -> three consecutive mac pairs, mac_a_tlast only on third; model returns 0x4600 with r_tlast -> res_tdata=0x4600, res_tvalid=1.
REQ-030 cmd_len=2, b_tvalid low 2 cycles between pairs -> a_tready=0 those cycles, mac inputs 0x0000, result unchanged vs. no stall.
REQ-031 cmd_len=0 -> DONE one cycle after cmd, res_tdata=0x0000, no mac_a_tlast pulse.
REQ-032 res_ready held low 5 cycles -> res_tvalid/res_tdata stable, cmd_ready=0, then IDLE on accept.
REQ-033 aresetn pulsed low after 1 of 4 pairs -> all outputs reset values, no res_tvalid, next cmd_len=1 completes normally.
REQ-034 With MAC_SEQ_TIMEOUT_EN, TIMEOUT=8, mac_r_tlast never asserted -> after 8 DRAIN cycles res_tdata=0x7E00, err=1.
